// File: rtl/pico_io_ctrl_if.sv
// KCPSM6 port-bus signals between the processor and pico_io_ctrl.
// master = processor side, slave = controller side.
interface pico_io_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id,
    output out_port,
    output write_strobe,
    output k_write_strobe,
    output read_strobe,
    output interrupt_ack,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  port_id,
    input  out_port,
    input  write_strobe,
    input  k_write_strobe,
    input  read_strobe,
    input  interrupt_ack,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/pico_io_ctrl.sv
// KCPSM6 port decoder: 4 output regs, registered input mux,
// and a 4-source edge-triggered interrupt controller.
module pico_io_ctrl #(
  parameter logic [7:0] OUT_BASE      = 8'h00,
  parameter logic [7:0] IN_BASE       = 8'h10,
  parameter logic [7:0] IRQ_STAT_PORT = 8'h20,
  parameter logic [7:0] IRQ_MASK_PORT = 8'h21
) (
  input  logic        clk,
  input  logic        reset,
  pico_io_ctrl_if.slave bus,
  output logic [31:0] out_regs,
  output logic [3:0]  out_stb,
  input  logic [31:0] in_data,
  output logic [3:0]  in_rd_stb,
  input  logic [3:0]  irq_src
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] out_regs_q, out_regs_d;
  logic [3:0]  out_stb_q, out_stb_d;
  logic [3:0]  in_rd_stb_q, in_rd_stb_d;
  logic [7:0]  in_port_q, in_port_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  irq_prev_q;

  logic [7:0]  out_off;
  logic [7:0]  in_off;
  logic        in_hit;
  logic        stat_hit;
  logic        mask_hit;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [3:0]  clr;
  logic        active;
  logic        irq_o;

  assign out_off  = bus.port_id - OUT_BASE;
  assign in_off   = bus.port_id - IN_BASE;
  assign in_hit   = (in_off[7:2] == 6'd0);
  assign stat_hit = (bus.port_id == IRQ_STAT_PORT);
  assign mask_hit = (bus.port_id == IRQ_MASK_PORT);
  assign active   = |(pending_q & mask_q);

  // OUTPUT takes precedence; OUTPUTK only decodes the low nibble
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = 2'd0;
    if (bus.write_strobe) begin
      wr_en  = (out_off[7:2] == 6'd0);
      wr_idx = out_off[1:0];
    end else if (bus.k_write_strobe) begin
      wr_en  = (bus.port_id[3:2] == 2'b00);
      wr_idx = bus.port_id[1:0];
    end
  end

  always_comb begin
    out_regs_d = out_regs_q;
    out_stb_d  = 4'd0;
    if (wr_en) begin
      out_regs_d[8*wr_idx +: 8] = bus.out_port;
      out_stb_d[wr_idx]         = 1'b1;
    end
  end

  always_comb begin
    in_port_d   = 8'h00;
    in_rd_stb_d = 4'd0;
    unique case (1'b1)
      in_hit: begin
        in_port_d = in_data[8*in_off[1:0] +: 8];
        in_rd_stb_d[in_off[1:0]] = bus.read_strobe;
      end
      stat_hit: in_port_d = {4'b0, pending_q};
      mask_hit: in_port_d = {4'b0, mask_q};
      default:  in_port_d = 8'h00;
    endcase
  end

  // a new edge beats a same-cycle write-1-to-clear
  always_comb begin
    clr       = (bus.write_strobe && stat_hit) ? bus.out_port[3:0] : 4'd0;
    pending_d = (pending_q & ~clr) | (irq_src & ~irq_prev_q);
    mask_d    = (bus.write_strobe && mask_hit) ? bus.out_port[3:0] : mask_q;
  end

  always_comb begin
    state_d = state_q;
    irq_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (active) state_d = ASSERT;
      end
      ASSERT: begin
        irq_o = 1'b1;
        if (bus.interrupt_ack) state_d = SERVICE;
        else if (!active)      state_d = IDLE;
      end
      SERVICE: begin
        if (!active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_regs_q  <= 32'd0;
      out_stb_q   <= 4'd0;
      in_rd_stb_q <= 4'd0;
      in_port_q   <= 8'h00;
      pending_q   <= 4'd0;
      mask_q      <= 4'd0;
      irq_prev_q  <= irq_src;
    end else begin
      state_q     <= state_d;
      out_regs_q  <= out_regs_d;
      out_stb_q   <= out_stb_d;
      in_rd_stb_q <= in_rd_stb_d;
      in_port_q   <= in_port_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_prev_q  <= irq_src;
    end
  end

  assign out_regs      = out_regs_q;
  assign out_stb       = out_stb_q;
  assign in_rd_stb     = in_rd_stb_q;
  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_o;

endmodule

// File: tb/tb_pico_io_ctrl.sv
// Self-checking bench for pico_io_ctrl: directed literal cases
// followed by randomized traffic against a behavioural model.
module tb_pico_io_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] out_regs;
  logic [3:0]  out_stb;
  logic [31:0] in_data;
  logic [3:0]  in_rd_stb;
  logic [3:0]  irq_src;

  int checks   = 0;
  int failures = 0;

  pico_io_ctrl_if bus ();

  pico_io_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .out_regs  (out_regs),
    .out_stb   (out_stb),
    .in_data   (in_data),
    .in_rd_stb (in_rd_stb),
    .irq_src   (irq_src)
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [7:0] m_out [4];
  logic [3:0] m_stb, m_rd, m_pend, m_mask, m_prev;
  logic [7:0] m_in;
  int         m_st;
  bit         m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step;
    logic [3:0] rise, clr;
    logic       act;
    int         idx;
    int         pid;
    pid = int'(bus.port_id);
    if (reset) begin
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
      m_stb = 0; m_rd = 0; m_in = 0;
      m_pend = 0; m_mask = 0; m_prev = irq_src; m_st = 0;
      m_valid = 1'b1;
      return;
    end
    act = |(m_pend & m_mask);
    if (pid >= 16 && pid <= 19)
      m_in = 8'((in_data >> (8 * (pid - 16))) & 32'hFF);
    else if (pid == 32) m_in = {4'b0, m_pend};
    else if (pid == 33) m_in = {4'b0, m_mask};
    else m_in = 8'h00;
    idx = -1;
    if (bus.write_strobe) begin
      if (pid < 4) idx = pid;
    end else if (bus.k_write_strobe) begin
      if ((pid % 16) < 4) idx = pid % 16;
    end
    m_stb = 0;
    if (idx >= 0) begin
      m_out[idx] = bus.out_port;
      m_stb[idx] = 1'b1;
    end
    m_rd = 0;
    if (bus.read_strobe && pid >= 16 && pid <= 19) m_rd[pid-16] = 1'b1;
    case (m_st)
      0: if (act) m_st = 1;
      1: if (bus.interrupt_ack) m_st = 2; else if (!act) m_st = 0;
      default: if (!act) m_st = 0;
    endcase
    clr = (bus.write_strobe && pid == 32) ? bus.out_port[3:0] : 4'd0;
    rise = irq_src & ~m_prev;
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq_src;
    if (bus.write_strobe && pid == 33) m_mask = bus.out_port[3:0];
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_valid) begin
      chk("out_regs", out_regs, {m_out[3], m_out[2], m_out[1], m_out[0]});
      chk("out_stb", 32'(out_stb), 32'(m_stb));
      chk("in_rd_stb", 32'(in_rd_stb), 32'(m_rd));
      chk("in_port", 32'(bus.in_port), 32'(m_in));
      chk("interrupt", 32'(bus.interrupt), 32'(m_st == 1));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic ws, input logic ks, input logic rs,
                     input logic [7:0] pid, input logic [7:0] dat);
    bus.write_strobe   = ws;
    bus.k_write_strobe = ks;
    bus.read_strobe    = rs;
    bus.port_id        = pid;
    bus.out_port       = dat;
  endtask

  initial begin
    reset = 1'b1;
    irq_src = 4'd0;
    in_data = 32'hDDCCBBAA;
    bus.interrupt_ack = 1'b0;
    drv(0, 0, 0, 8'h00, 8'h00);
    tick; tick;
    chk("rst_out_regs", out_regs, 32'h0);
    chk("rst_interrupt", 32'(bus.interrupt), 32'h0);
    chk("rst_in_port", 32'(bus.in_port), 32'h0);
    reset = 1'b0;
    tick;

    drv(1, 0, 0, 8'h02, 8'hA5); tick; drv(0, 0, 0, 8'h02, 8'h00);
    chk("wr_a5", out_regs, 32'h00A50000);
    chk("wr_stb", 32'(out_stb), 32'h4);
    tick;
    chk("wr_stb_clr", 32'(out_stb), 32'h0);

    drv(0, 1, 0, 8'hF1, 8'h3C); tick; drv(0, 0, 0, 8'h00, 8'h00);
    chk("k_wr", out_regs, 32'h00A53C00);
    drv(1, 1, 0, 8'h11, 8'h77); tick; drv(0, 0, 0, 8'h00, 8'h00);
    chk("ws_wins_nowr", out_regs, 32'h00A53C00);
    chk("ws_wins_nostb", 32'(out_stb), 32'h0);
    drv(1, 1, 0, 8'h00, 8'h11); tick; drv(0, 0, 0, 8'h00, 8'h00);
    chk("both_b0", out_regs, 32'h00A53C11);
    chk("both_stb", 32'(out_stb), 32'h1);

    drv(0, 0, 1, 8'h12, 8'h00); tick; drv(0, 0, 0, 8'h12, 8'h00);
    chk("in_cc", 32'(bus.in_port), 32'hCC);
    chk("rd_stb", 32'(in_rd_stb), 32'h4);
    drv(0, 0, 0, 8'h55, 8'h00); tick;
    chk("in_none", 32'(bus.in_port), 32'h0);
    chk("rd_stb_clr", 32'(in_rd_stb), 32'h0);

    drv(1, 0, 0, 8'h21, 8'h02); tick; drv(0, 0, 0, 8'h20, 8'h00);
    irq_src = 4'b0010; tick; irq_src = 4'b0000; tick;
    chk("pend_02", 32'(bus.in_port), 32'h02);
    chk("irq_on", 32'(bus.interrupt), 32'h1);
    bus.interrupt_ack = 1'b1; tick; bus.interrupt_ack = 1'b0;
    chk("ack_off", 32'(bus.interrupt), 32'h0);
    tick; tick;
    chk("svc_hold", 32'(bus.interrupt), 32'h0);
    drv(1, 0, 0, 8'h20, 8'h02); tick; drv(0, 0, 0, 8'h20, 8'h00); tick;
    chk("w1c_pend", 32'(bus.in_port), 32'h0);
    irq_src = 4'b0010; tick; irq_src = 4'b0000; tick;
    chk("idle_rearm", 32'(bus.interrupt), 32'h1);
    drv(1, 0, 0, 8'h20, 8'h02); tick; drv(0, 0, 0, 8'h20, 8'h00); tick;
    chk("clr_drop", 32'(bus.interrupt), 32'h0);

    irq_src = 4'b1000;
    drv(1, 0, 0, 8'h20, 8'h08); tick; drv(0, 0, 0, 8'h20, 8'h00); tick;
    chk("set_wins", 32'(bus.in_port), 32'h08);
    irq_src = 4'b0000;
    drv(1, 0, 0, 8'h20, 8'h08); tick; drv(0, 0, 0, 8'h20, 8'h00); tick;
    chk("w1c_b3", 32'(bus.in_port), 32'h00);

    irq_src = 4'b0001; reset = 1'b1; tick; reset = 1'b0; tick; tick;
    chk("held_src", 32'(bus.in_port), 32'h00);
    irq_src = 4'b0000;

    drv(1, 0, 0, 8'h03, 8'hFF); tick;
    drv(1, 0, 0, 8'h21, 8'h02); tick; drv(0, 0, 0, 8'h21, 8'h00);
    irq_src = 4'b0010; tick; irq_src = 4'b0000; tick;
    chk("pre_rst_irq", 32'(bus.interrupt), 32'h1);
    reset = 1'b1; tick; reset = 1'b0;
    chk("rst_irq", 32'(bus.interrupt), 32'h0);
    chk("rst_regs", out_regs, 32'h0);
    tick;
    chk("rst_mask", 32'(bus.in_port), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      logic [7:0] pid;
      case ($urandom_range(0, 5))
        0: pid = 8'($urandom_range(0, 3));
        1: pid = 8'($urandom_range(16, 19));
        2: pid = 8'($urandom_range(32, 33));
        3: pid = 8'($urandom_range(0, 255));
        4: pid = 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 5));
        default: pid = 8'($urandom_range(32, 33));
      endcase
      drv($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) == 0, pid, 8'($urandom));
      bus.interrupt_ack = ($urandom_range(0, 3) == 0);
      irq_src = irq_src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      in_data = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      tick;
    end
    reset = 1'b0;
    drv(0, 0, 0, 8'h00, 8'h00);
    bus.interrupt_ack = 1'b0;
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
